// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, message-granular arbiter sharing one UART TX FIFO
//            write port among NUM_REQ requesters, with a stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DATA_BITS    = 8,
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                           Clock,
    input  logic                           ResetN,
    input  logic [NUM_REQ-1:0]             ReqValid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   ReqData,
    input  logic [NUM_REQ-1:0]             ReqLast,
    output logic [NUM_REQ-1:0]             ReqReady,
    input  logic                           TxFull,
    output logic                           WriteUart,
    output logic [DATA_BITS-1:0]           WriteData,
    output logic [NUM_REQ-1:0]             Grant,
    output logic                           Busy,
    output logic                           Abort
);

    localparam int c_ptr_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(IDLE_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(IDLE_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_ptr_w-1:0]   r_owner;
    logic [c_ptr_w-1:0]   r_pointer;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_abort;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [c_ptr_w-1:0]   w_owner_nxt;
    logic [c_ptr_w-1:0]   w_pointer_nxt;
    logic [c_cnt_w-1:0]   w_count_nxt;
    logic                 w_abort_nxt;

    logic [NUM_REQ-1:0]   w_rot;
    logic [c_ptr_w-1:0]   w_offset;
    logic [c_ptr_w-1:0]   w_sel;
    logic [c_ptr_w-1:0]   w_owner_inc;
    logic                 w_xfer;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic                 w_accept;
    logic [DATA_BITS-1:0] w_data;

    // Round-robin pick: rotate requests so Pointer lands at bit 0, take the lowest set bit.
    always_comb begin
        w_rot    = NUM_REQ'({ReqValid, ReqValid} >> r_pointer);
        w_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = c_ptr_w'(k);
            end
        end
        w_sel       = c_ptr_w'((int'(r_pointer) + int'(w_offset)) % NUM_REQ);
        w_owner_inc = c_ptr_w'((int'(r_owner) + 1) % NUM_REQ);
    end

    // Owner-side datapath: grant is one-hot, so an OR-mux selects the owner's byte.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_data = w_data | ReqData[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Reset gates the handshake combinationally so nothing is written in a reset cycle.
    assign w_xfer      = (r_state == ST_XFER);
    assign w_own_valid = |(ReqValid & r_grant);
    assign w_own_last  = |(ReqLast & r_grant);
    assign w_accept    = ResetN & w_xfer & w_own_valid & ~TxFull;

    assign ReqReady  = (ResetN & w_xfer & ~TxFull) ? r_grant : '0;
    assign WriteUart = w_accept;
    assign WriteData = w_data;
    assign Grant     = r_grant;
    assign Busy      = w_xfer;
    assign Abort     = r_abort;

    // Next-state logic: grant per message, release on Last or on watchdog expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_pointer_nxt = r_pointer;
        w_count_nxt   = r_count;
        w_abort_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|ReqValid) begin
                    w_state_nxt = ST_XFER;
                    w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
                    w_owner_nxt = w_sel;
                    w_count_nxt = '0;
                end
            end
            ST_XFER: begin
                if (w_accept) begin
                    w_count_nxt = '0;
                    if (w_own_last) begin
                        w_state_nxt   = ST_IDLE;
                        w_grant_nxt   = '0;
                        w_pointer_nxt = w_owner_inc;
                    end
                end else if (!w_own_valid) begin
                    // Owner is not presenting data: a stall, not backpressure.
                    if (r_count == c_cnt_last) begin
                        w_abort_nxt   = 1'b1;
                        w_state_nxt   = ST_IDLE;
                        w_grant_nxt   = '0;
                        w_pointer_nxt = w_owner_inc;
                        w_count_nxt   = '0;
                    end else begin
                        w_count_nxt = r_count + c_cnt_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_pointer <= '0;
            r_count   <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_pointer <= w_pointer_nxt;
            r_count   <= w_count_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scenario bench for uart_tx_arbiter with a write-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int DB = 8;
    localparam int NR = 4;
    localparam int TO = 4;

    logic              Clock = 1'b0;
    logic              ResetN = 1'b0;
    logic [NR-1:0]     ReqValid = '0;
    logic [NR*DB-1:0]  ReqData = '0;
    logic [NR-1:0]     ReqLast = '0;
    logic [NR-1:0]     ReqReady;
    logic              TxFull = 1'b0;
    logic              WriteUart;
    logic [DB-1:0]     WriteData;
    logic [NR-1:0]     Grant;
    logic              Busy;
    logic              Abort;

    always #5 Clock = ~Clock;

    uart_tx_arbiter #(.DATA_BITS(DB), .NUM_REQ(NR), .IDLE_TIMEOUT(TO)) dut (
        .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqLast(ReqLast), .ReqReady(ReqReady), .TxFull(TxFull),
        .WriteUart(WriteUart), .WriteData(WriteData), .Grant(Grant),
        .Busy(Busy), .Abort(Abort)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [8:0]    mem [NR][32];
    int            head [NR];
    int            tail [NR];
    logic [DB-1:0] sb [$];
    logic [NR-1:0] acc_q = '0;
    logic          rstn_drv = 1'b0;
    logic          tx_full_drv = 1'b0;

    // One clock: retire accepted bytes, drive the next inputs, then sample mid-cycle.
    task automatic tick();
        logic [DB-1:0] exp_b;
        @(posedge Clock);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_q[i] && head[i] != tail[i]) head[i]++;
        end
        ResetN = rstn_drv;
        TxFull = tx_full_drv;
        for (int i = 0; i < NR; i++) begin
            if (head[i] != tail[i]) begin
                ReqValid[i]           = 1'b1;
                ReqData[i*DB +: DB]   = mem[i][head[i]][7:0];
                ReqLast[i]            = mem[i][head[i]][8];
            end else begin
                ReqValid[i]           = 1'b0;
                ReqData[i*DB +: DB]   = '0;
                ReqLast[i]            = 1'b0;
            end
        end
        @(negedge Clock);
        acc_q = ReqValid & ReqReady;
        if (WriteUart === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL write_unexpected: got WriteData=%h, required no write", WriteData);
            end else begin
                exp_b = sb.pop_front();
                if (WriteData !== exp_b) begin
                    n_bad++;
                    $display("FAIL write_data: got %h, required %h", WriteData, exp_b);
                end
            end
        end
    endtask

    // Queue an n-byte message for requester r; optionally expect it on the TX port.
    task automatic msg(input int r, input logic [7:0] base, input int n,
                       input bit last_end, input bit push);
        for (int k = 0; k < n; k++) begin
            mem[r][tail[r]] = {(last_end && k == n - 1), base + 8'(k)};
            tail[r]++;
            if (push) sb.push_back(base + 8'(k));
        end
    endtask

    task automatic test_reset();
        rstn_drv = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (Grant !== 4'b0000 || Busy !== 1'b0 || Abort !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got Grant=%b Busy=%b Abort=%b, required 0000 0 0", Grant, Busy, Abort);
        end
        n_cmp++;
        if (WriteUart !== 1'b0 || ReqReady !== 4'b0000 || dut.r_pointer !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got WriteUart=%b ReqReady=%b Pointer=%0d, required 0 0000 0",
                     WriteUart, ReqReady, dut.r_pointer);
        end
        rstn_drv = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [NR-1:0] exp_g [5] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        logic          exp_w [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        msg(1, 8'hA1, 3, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (Grant !== exp_g[c] || WriteUart !== exp_w[c]) begin
                n_bad++;
                $display("FAIL single_c%0d: got Grant=%b WriteUart=%b, required %b %b",
                         c, Grant, WriteUart, exp_g[c], exp_w[c]);
            end
        end
        n_cmp++;
        if (dut.r_pointer !== 2'd2 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_release: got Pointer=%0d Busy=%b, required 2 0", dut.r_pointer, Busy);
        end
    endtask

    task automatic test_watchdog();
        logic [NR-1:0] exp_g [10] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                      4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        logic          exp_a [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic          exp_w [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        msg(2, 8'h50, 1, 1'b0, 1'b1);
        msg(3, 8'h60, 2, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (Grant !== exp_g[c] || Abort !== exp_a[(c + 9) % 10 == 5 ? 5 : 0] && c == 6
                || (c != 6 && Abort !== 1'b0) || WriteUart !== exp_w[c]) begin
                n_bad++;
                $display("FAIL watchdog_c%0d: got Grant=%b Abort=%b WriteUart=%b, required %b %b %b",
                         c, Grant, Abort, WriteUart, exp_g[c], (c == 6), exp_w[c]);
            end
            if (c == 6) begin
                n_cmp++;
                if (dut.r_pointer !== 2'd3 || Busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL watchdog_release: got Pointer=%0d Busy=%b, required 3 0", dut.r_pointer, Busy);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_g [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100,
                                      4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        logic          exp_w [10] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        msg(0, 8'hC0, 2, 1'b1, 1'b1);
        msg(2, 8'hD0, 2, 1'b1, 1'b1);
        msg(3, 8'hE0, 2, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (Grant !== exp_g[c] || WriteUart !== exp_w[c]) begin
                n_bad++;
                $display("FAIL contention_c%0d: got Grant=%b WriteUart=%b, required %b %b",
                         c, Grant, WriteUart, exp_g[c], exp_w[c]);
            end
        end
        n_cmp++;
        if (dut.r_pointer !== 2'd0) begin
            n_bad++;
            $display("FAIL contention_pointer: got %0d, required 0", dut.r_pointer);
        end
    endtask

    task automatic test_last_waiting();
        logic [NR-1:0] exp_g [8] = '{4'b0010, 4'b0000, 4'b0100, 4'b0100,
                                     4'b0000, 4'b0001, 4'b0001, 4'b0000};
        logic          exp_w [8] = '{1, 0, 1, 1, 0, 1, 1, 0};
        msg(1, 8'hF0, 2, 1'b1, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (Grant !== 4'b0010 || WriteUart !== 1'b1) begin
            n_bad++;
            $display("FAIL last_wait_grant: got Grant=%b WriteUart=%b, required 0010 1", Grant, WriteUart);
        end
        msg(2, 8'h70, 2, 1'b1, 1'b1);
        msg(0, 8'h40, 2, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (Grant !== exp_g[c] || WriteUart !== exp_w[c]) begin
                n_bad++;
                $display("FAIL last_wait_c%0d: got Grant=%b WriteUart=%b, required %b %b",
                         c, Grant, WriteUart, exp_g[c], exp_w[c]);
            end
            if (c == 1) begin
                n_cmp++;
                if (dut.r_pointer !== 2'd2) begin
                    n_bad++;
                    $display("FAIL last_wait_pointer: got %0d, required 2", dut.r_pointer);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        msg(0, 8'h80, 4, 1'b1, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (Grant !== 4'b0001 || WriteUart !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_start: got Grant=%b WriteUart=%b, required 0001 1", Grant, WriteUart);
        end
        tx_full_drv = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (ReqReady !== 4'b0000 || WriteUart !== 1'b0 || Abort !== 1'b0 || Grant !== 4'b0001) begin
                n_bad++;
                $display("FAIL bp_hold_c%0d: got ReqReady=%b WriteUart=%b Abort=%b Grant=%b, required 0000 0 0 0001",
                         c, ReqReady, WriteUart, Abort, Grant);
            end
        end
        tx_full_drv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (WriteUart !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_resume_c%0d: got WriteUart=%b, required 1", c, WriteUart);
            end
        end
        tick();
        n_cmp++;
        if (Grant !== 4'b0000 || Abort !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_end: got Grant=%b Abort=%b, required 0000 0", Grant, Abort);
        end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] exp_g [5] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        msg(3, 8'h30, 1, 1'b0, 1'b1);
        msg(3, 8'h31, 2, 1'b1, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (Grant !== 4'b1000 || WriteUart !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_start: got Grant=%b WriteUart=%b, required 1000 1", Grant, WriteUart);
        end
        rstn_drv = 1'b0;
        tick();
        n_cmp++;
        if (WriteUart !== 1'b0 || ReqReady !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_mid_gate: got WriteUart=%b ReqReady=%b, required 0 0000", WriteUart, ReqReady);
        end
        rstn_drv = 1'b1;
        head[3] = tail[3];
        tick();
        n_cmp++;
        if (Grant !== 4'b0000 || Busy !== 1'b0 || dut.r_pointer !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mid_after: got Grant=%b Busy=%b Pointer=%0d, required 0000 0 0",
                     Grant, Busy, dut.r_pointer);
        end
        msg(0, 8'h11, 1, 1'b1, 1'b1);
        msg(3, 8'h33, 1, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (Grant !== exp_g[c]) begin
                n_bad++;
                $display("FAIL rst_mid_restart_c%0d: got Grant=%b, required %b", c, Grant, exp_g[c]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        test_reset();
        test_single();
        test_watchdog();
        test_contention();
        test_last_waiting();
        test_backpressure();
        test_reset_mid();
        repeat (2) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d bytes unwritten, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
